btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Front-end conditioner for the game's three push-buttons. It synchronises the raw active-low button inputs and debounces each one independently. It then emits a single-cycle press event carrying a 2-bit button code, which is the stimulus consumed by the game FSM's input-receive and choice-verification logic. Simultaneous or overlapping presses are rejected and flagged, so that the game never sees an ambiguous choice.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 50000: number of consecutive cycles an input must stay changed before it is accepted (1 ms at 50 MHz); must be ≥ 2.
- REPEAT_CYCLES, default 25000000: auto-repeat period while a button is held. Used only with BTN_AUTOREPEAT_EN.

Ports:
- clock, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-low.
- btn_n, input, 3: raw button pins, active-low (0 = pressed), asynchronous to clock.
- btn_level, output, 3: debounced button state, active-high (1 = held).
- press_valid, output, 1: one-cycle pulse marking an accepted press.
- press_code, output, 2: index (0..2) of the accepted button; valid only while press_valid = 1, otherwise holds its last value. Code 3 is never produced.
- multi_press, output, 1: one-cycle pulse when a press is rejected because of a conflict.

## Operation
- Synchroniser: two flip-flops per bit, sync1 then sync2, on the inverted btn_n.
- Per-button debounce uses a counter of width $clog2(DEBOUNCE_CYCLES) and a debounced bit deb[i]:
  - When sync2[i] equals deb[i], the counter clears.
  - When they differ and counter < DEBOUNCE_CYCLES−1, the counter increments.
  - When they differ and counter = DEBOUNCE_CYCLES−1, deb[i] takes sync2[i] and the counter clears.
- btn_level = deb.
- rise[i] = deb[i] going 0→1, computed against a registered copy of deb.
- Arbitration FSM, one instance, states IDLE and HELD:
  - In IDLE with exactly one rise: press_valid = 1, press_code = its index, go to HELD.
  - In IDLE with more than one rise in the same cycle: multi_press = 1, no press_valid, go to HELD.
  - In HELD, any rise (a second button pressed while one is down): multi_press = 1, no press_valid, stay in HELD.
  - In HELD, when all deb bits are 0: go to IDLE.
- Releases never generate events.
- press_valid and multi_press are never high in the same cycle.

## Timing
- Reset (reset = 0 at a clock edge) clears the following:
  - sync1, sync2, deb, the deb copy, and all counters clear to 0.
  - The FSM returns to IDLE.
  - btn_level = 3'b000, press_valid = 0, press_code = 2'b00, multi_press = 0.
- A reset asserted while a button is held takes priority. After release of reset, a still-held button re-debounces and produces a fresh press event.
- Latency: btn_n low, stable, first sampled at edge 0:
  - deb rises at edge DEBOUNCE_CYCLES+1.
  - press_valid is high for exactly the cycle after edge DEBOUNCE_CYCLES+2.
- A release takes the same latency to deassert btn_level.
- Glitch rejection: any mismatch lasting fewer than DEBOUNCE_CYCLES cycles at sync2 leaves deb unchanged and produces no event.
- Counters saturate by construction (they clear on accept), so there is no wrap-around.

## Configuration
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - In HELD, with exactly one deb bit set and no conflict flagged since entering HELD, a repeat counter runs.
  - Every REPEAT_CYCLES cycles it emits press_valid with that button's code.
  - The repeat counter clears on leaving HELD or on any conflict.
- Undefined: the repeat logic is absent. Exactly one press_valid is produced per accepted press, however long the button is held.

## Test plan
Use DEBOUNCE_CYCLES = 4 and REPEAT_CYCLES = 10 for simulation.
- Press and release one button: btn_n = 3'b101 from edge 0 for 20 cycles, then 3'b111 → btn_level = 3'b010 from edge 5; press_valid high in the single cycle after edge 6 with press_code = 1; btn_level returns to 0 four cycles plus sync delay after release; no further pulses without the macro.
- Bounce: btn_n[0] toggles low for 2 cycles, high for 1, low for 3, then stable low → no event during the bounce; a single press_valid with press_code = 0, 6 cycles after the last toggle.
- Simultaneous press: btn_n goes 3'b111 → 3'b010 in one cycle → multi_press pulses once, press_valid stays 0, btn_level = 3'b101.
- Overlap: press btn 2 (press_valid, code 2), then press btn 0 while btn 2 is held → multi_press pulses and no second press_valid; release both, then press btn 0 → press_valid with code 0.
- Reset mid-hold: hold btn 1 past its event, then pulse reset = 0 for 1 cycle → all outputs 0 in the following cycle; a second press_valid with code 1 appears 6 cycles after reset is released.
- With BTN_AUTOREPEAT_EN: hold btn 2 for 40 cycles → the initial press_valid, then repeats every 10 cycles while held (3 repeats), each with code 2.

Source files
------------

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Front end for the game's three push-buttons. The raw active-low pins are
// synchronised into the clock domain, each one is debounced on its own, and a
// single arbitration FSM turns debounced rising edges into one-cycle press
// events carrying a 2-bit button code. Presses that overlap or arrive together
// are rejected and flagged, so the game never sees an ambiguous choice.
//
// Optional feature (macro BTN_AUTOREPEAT_EN): while exactly one button is held
// without any conflict since the hold began, press_valid is re-emitted every
// REPEAT_CYCLES cycles. With the macro undefined, each accepted press gives
// exactly one press_valid however long the button stays down.
//
// Parameters:
//   DEBOUNCE_CYCLES - cycles a changed input must persist before acceptance (>= 2)
//   REPEAT_CYCLES   - auto-repeat period, only used with BTN_AUTOREPEAT_EN (>= 2)
//
// Ports:
//   clock       - system clock, rising edge
//   reset       - synchronous, active-low
//   btn_n       - raw button pins, active-low, asynchronous to clock
//   btn_level   - debounced button state, active-high
//   press_valid - one-cycle pulse for an accepted press
//   press_code  - index (0..2) of the accepted button, holds between presses
//   multi_press - one-cycle pulse when a press is rejected due to a conflict
// -----------------------------------------------------------------------------
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] btn_n,
   output logic [2:0] btn_level,
   output logic       press_valid,
   output logic [1:0] press_code,
   output logic       multi_press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES - 1);

   // Catch nonsensical parameter values when the design is elaborated.
   if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : gBadParams
      $error("btn_conditioner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
   end

   typedef enum logic {
      IDLE,
      HELD
   } state_t;

   logic [2:0]    sync1_q, sync2_q;
   logic [2:0]    deb_q, deb_d;
   logic [2:0]    debPrev_q;
   logic [CW-1:0] cnt_q [3];
   logic [CW-1:0] cnt_d [3];
   logic [2:0]    rise;
   logic          singleRise;

   state_t        state_q, state_d;
   logic          pressValid_q, pressValid_d;
   logic          multiPress_q, multiPress_d;
   logic [1:0]    pressCode_q, pressCode_d;

`ifdef BTN_AUTOREPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep_q, rep_d;
   logic          conflict_q, conflict_d;
   logic          oneHeld;

   assign oneHeld = (deb_q == 3'b001) || (deb_q == 3'b010) || (deb_q == 3'b100);
`endif

   // Lowest set bit wins; callers only pass one-hot vectors.
   function automatic logic [1:0] encode(input logic [2:0] v);
      encode = v[0] ? 2'd0 : (v[1] ? 2'd1 : 2'd2);
   endfunction

   // Two-stage synchroniser on the inverted pins so everything downstream
   // works with active-high "pressed" bits.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_q <= 3'b000;
         sync2_q <= 3'b000;
      end else begin
         sync1_q <= ~btn_n;
         sync2_q <= sync1_q;
      end
   end

   // Per-button debounce: the counter measures how long sync2 has disagreed
   // with the accepted level and restarts whenever they agree again. Reaching
   // the last count flips the level and restarts the counter, so it can never
   // wrap around.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DEB_MAX) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Debounced level, its one-cycle-old copy for edge detection, and counters.
   always_ff @(posedge clock) begin
      if (!reset) begin
         deb_q     <= 3'b000;
         debPrev_q <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         deb_q     <= deb_d;
         debPrev_q <= deb_q;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign rise       = deb_q & ~debPrev_q;
   assign singleRise = (rise == 3'b001) || (rise == 3'b010) || (rise == 3'b100);

   // Arbitration: a lone rising edge from IDLE is a valid press; several at
   // once, or any new rise while something is already held, is a conflict.
   // The FSM only returns to IDLE once every button has been released, and
   // releases themselves never produce events.
   always_comb begin
      state_d      = state_q;
      pressValid_d = 1'b0;
      multiPress_d = 1'b0;
      pressCode_d  = pressCode_q;
`ifdef BTN_AUTOREPEAT_EN
      rep_d        = '0;
      conflict_d   = conflict_q;
`endif
      case (state_q)
         IDLE: begin
            if (rise != 3'b000) begin
               state_d = HELD;
               if (singleRise) begin
                  pressValid_d = 1'b1;
                  pressCode_d  = encode(rise);
               end else begin
                  multiPress_d = 1'b1;
               end
`ifdef BTN_AUTOREPEAT_EN
               conflict_d = !singleRise;
`endif
            end
         end
         HELD: begin
            if (rise != 3'b000) begin
               multiPress_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
               conflict_d   = 1'b1;
`endif
            end else if (deb_q == 3'b000) begin
               state_d = IDLE;
`ifdef BTN_AUTOREPEAT_EN
               conflict_d = 1'b0;
`endif
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (!conflict_q && oneHeld) begin
               // Clean single hold: re-emit the press once per period.
               if (rep_q == REP_MAX) begin
                  pressValid_d = 1'b1;
                  pressCode_d  = encode(deb_q);
               end else begin
                  rep_d = rep_q + 1'b1;
               end
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and registered event outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= IDLE;
         pressValid_q <= 1'b0;
         multiPress_q <= 1'b0;
         pressCode_q  <= 2'b00;
`ifdef BTN_AUTOREPEAT_EN
         rep_q        <= '0;
         conflict_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pressValid_q <= pressValid_d;
         multiPress_q <= multiPress_d;
         pressCode_q  <= pressCode_d;
`ifdef BTN_AUTOREPEAT_EN
         rep_q        <= rep_d;
         conflict_q   <= conflict_d;
`endif
      end
   end

   assign btn_level   = deb_q;
   assign press_valid = pressValid_q;
   assign press_code  = pressCode_q;
   assign multi_press = multiPress_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Self-checking bench for btn_conditioner with DEBOUNCE_CYCLES = 4 and
// REPEAT_CYCLES = 10. A behavioural model tracks what the outputs must be
// from the button history (a sampled input must persist for DEBOUNCE_CYCLES
// consecutive synchronised samples to be accepted; lone rises are presses,
// anything overlapping is a conflict). A negedge process compares the DUT to
// the model every cycle; directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

   localparam int DEB = 4;
   localparam int REP = 10;

   logic       clock;
   logic       reset;
   logic [2:0] btn_n;
   logic [2:0] btn_level;
   logic       press_valid;
   logic [1:0] press_code;
   logic       multi_press;

   int compareCount = 0;
   int failCount    = 0;
   int pvCount      = 0;
   int mpCount      = 0;
   bit checking     = 0;

   btn_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_CYCLES  (REP)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .btn_n      (btn_n),
      .btn_level  (btn_level),
      .press_valid(press_valid),
      .press_code (press_code),
      .multi_press(multi_press)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   logic [2:0] mSyncA, mSyncB;
   logic [2:0] histQ[$];
   logic [2:0] mDeb, mPrev;
   bit         mBusy, mConflict;
   int         mHold;
   logic [2:0] expLevel;
   logic       expPv, expMp;
   logic [1:0] expCode;

   initial begin
      mSyncA = '0; mSyncB = '0; mDeb = '0; mPrev = '0;
      mBusy = 0; mConflict = 0; mHold = 0;
      expLevel = '0; expPv = 0; expMp = 0; expCode = '0;
   end

   always @(posedge clock) begin
      logic [2:0] r;
      logic [2:0] s;
      int         nr;
      bit         allDiffer;
      if (!reset) begin
         mSyncA = '0; mSyncB = '0; histQ.delete();
         mDeb = '0; mPrev = '0; mBusy = 0; mConflict = 0; mHold = 0;
         expPv = 0; expMp = 0; expCode = '0;
      end else begin
         r = mDeb & ~mPrev;
         nr = $countones(r);
         expPv = 0;
         expMp = 0;
         if (!mBusy) begin
            if (nr == 1) begin
               expPv = 1; expCode = 2'($clog2(r)); mBusy = 1; mConflict = 0;
            end else if (nr > 1) begin
               expMp = 1; mBusy = 1; mConflict = 1;
            end
            mHold = 0;
         end else if (nr > 0) begin
            expMp = 1; mConflict = 1; mHold = 0;
         end else if (mDeb == 3'b000) begin
            mBusy = 0; mConflict = 0; mHold = 0;
         end else begin
`ifdef BTN_AUTOREPEAT_EN
            if (!mConflict && $countones(mDeb) == 1) begin
               mHold++;
               if (mHold == REP) begin
                  expPv = 1; expCode = 2'($clog2(mDeb)); mHold = 0;
               end
            end else begin
               mHold = 0;
            end
`endif
         end
         mPrev = mDeb;
         // Two-edge synchroniser delay, then the "stable for DEB samples" rule.
         s = mSyncB;
         mSyncB = mSyncA;
         mSyncA = ~btn_n;
         histQ.push_back(s);
         if (histQ.size() > DEB) void'(histQ.pop_front());
         if (histQ.size() == DEB) begin
            for (int i = 0; i < 3; i++) begin
               allDiffer = 1;
               foreach (histQ[k]) if (histQ[k][i] == mDeb[i]) allDiffer = 0;
               if (allDiffer) mDeb[i] = s[i];
            end
         end
      end
      expLevel = mDeb;
   end

   // ---------------- checking ----------------
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
      end
   endtask

   // Compare the DUT against the model every cycle once reset has been seen.
   always @(negedge clock) begin
      if (checking) begin
         checkOutput("btn_level", 32'(btn_level), 32'(expLevel));
         checkOutput("press_valid", 32'(press_valid), 32'(expPv));
         checkOutput("multi_press", 32'(multi_press), 32'(expMp));
         checkOutput("press_code", 32'(press_code), 32'(expCode));
         if (press_valid) pvCount++;
         if (multi_press) mpCount++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic applyStimulus(input logic [2:0] pattern, input int cycles);
      btn_n = pattern;
      repeat (cycles) @(posedge clock);
      #1;
   endtask

   task automatic pulseReset();
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      int pv0, mp0;
      int expScenario1;
      logic [2:0] pat;
      btn_n = 3'b111;
      reset = 1'b0;
      @(posedge clock);
      #1;
      checking = 1;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset_level", 32'(btn_level), 32'h0);
      checkOutput("reset_pv", 32'(press_valid), 32'h0);
      checkOutput("reset_code", 32'(press_code), 32'h0);
      checkOutput("reset_mp", 32'(multi_press), 32'h0);
      reset = 1'b1;
      applyStimulus(3'b111, 3);

      // Press and release button 1.
      pv0 = pvCount;
`ifdef BTN_AUTOREPEAT_EN
      expScenario1 = 2;
`else
      expScenario1 = 1;
`endif
      applyStimulus(3'b101, 5);
      checkOutput("s1_level_e4", 32'(btn_level), 32'h0);
      applyStimulus(3'b101, 1);
      checkOutput("s1_level_e5", 32'(btn_level), 32'h2);
      checkOutput("s1_pv_e5", 32'(press_valid), 32'h0);
      applyStimulus(3'b101, 1);
      checkOutput("s1_pv_e6", 32'(press_valid), 32'h1);
      checkOutput("s1_code_e6", 32'(press_code), 32'h1);
      applyStimulus(3'b101, 1);
      checkOutput("s1_pv_e7", 32'(press_valid), 32'h0);
      applyStimulus(3'b101, 12);
      applyStimulus(3'b111, 5);
      checkOutput("s1_level_rel_e24", 32'(btn_level), 32'h2);
      applyStimulus(3'b111, 1);
      checkOutput("s1_level_rel_e25", 32'(btn_level), 32'h0);
      applyStimulus(3'b111, 10);
      checkOutput("s1_pulse_count", 32'(pvCount - pv0), 32'(expScenario1));

      // Bounce on button 0.
      pv0 = pvCount;
      applyStimulus(3'b110, 2);
      applyStimulus(3'b111, 1);
      applyStimulus(3'b110, 6);
      checkOutput("bounce_pv_early", 32'(pvCount - pv0), 32'h0);
      applyStimulus(3'b110, 1);
      checkOutput("bounce_pv", 32'(press_valid), 32'h1);
      checkOutput("bounce_code", 32'(press_code), 32'h0);
      applyStimulus(3'b110, 3);
      applyStimulus(3'b111, 10);
      checkOutput("bounce_count", 32'(pvCount - pv0), 32'h1);

      // Simultaneous press of buttons 0 and 2.
      pv0 = pvCount; mp0 = mpCount;
      applyStimulus(3'b010, 7);
      checkOutput("simul_mp", 32'(multi_press), 32'h1);
      checkOutput("simul_pv", 32'(press_valid), 32'h0);
      checkOutput("simul_level", 32'(btn_level), 32'h5);
      applyStimulus(3'b010, 5);
      applyStimulus(3'b111, 10);
      checkOutput("simul_counts", 32'((mpCount - mp0) * 16 + (pvCount - pv0)), 32'h10);

      // Overlap: button 2, then button 0 while 2 is still down.
      pv0 = pvCount; mp0 = mpCount;
      applyStimulus(3'b011, 8);
      applyStimulus(3'b010, 10);
      applyStimulus(3'b111, 10);
      checkOutput("overlap_pv", 32'(pvCount - pv0), 32'h1);
      checkOutput("overlap_mp", 32'(mpCount - mp0), 32'h1);
      applyStimulus(3'b110, 7);
      checkOutput("overlap_after_pv", 32'(press_valid), 32'h1);
      checkOutput("overlap_after_code", 32'(press_code), 32'h0);
      applyStimulus(3'b111, 10);

      // Reset while button 1 is held.
      applyStimulus(3'b101, 10);
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      checkOutput("rst_level", 32'(btn_level), 32'h0);
      checkOutput("rst_pv", 32'(press_valid), 32'h0);
      checkOutput("rst_code", 32'(press_code), 32'h0);
      checkOutput("rst_mp", 32'(multi_press), 32'h0);
      applyStimulus(3'b101, 6);
      checkOutput("rst_repress_early", 32'(press_valid), 32'h0);
      applyStimulus(3'b101, 1);
      checkOutput("rst_repress_pv", 32'(press_valid), 32'h1);
      checkOutput("rst_repress_code", 32'(press_code), 32'h1);
      applyStimulus(3'b111, 10);

`ifdef BTN_AUTOREPEAT_EN
      // Long hold of button 2: initial press plus three repeats.
      pv0 = pvCount;
      applyStimulus(3'b011, 40);
      applyStimulus(3'b111, 10);
      checkOutput("repeat_count", 32'(pvCount - pv0), 32'h4);
`endif

      // Randomised phase: mixed hold lengths, glitches, overlaps and resets.
      for (int seg = 0; seg < 300; seg++) begin
         case ($urandom_range(0, 5))
            0, 1:    pat = 3'b111;
            2, 3:    pat = ~(3'b001 << $urandom_range(0, 2));
            default: pat = 3'($urandom_range(0, 7));
         endcase
         if ($urandom_range(0, 40) == 0) pulseReset();
         applyStimulus(pat, $urandom_range(1, 14));
      end
      applyStimulus(3'b111, 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
